// File: rtl/bram_fifo_axis_fwft.sv
// Single-clock AXI4-Stream FIFO on an inferred simple dual-port BRAM with a two-stage
// prefetch (registered RAM read, then output register) for first-word-fall-through.
module bram_fifo_axis_fwft #(
  parameter int unsigned N         = 10,
  parameter int unsigned B         = 16,
  parameter int unsigned AFULL_THR = 2**N - 4
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         flush,
  input  logic [B-1:0] s_axis_tdata,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  output logic [B-1:0] m_axis_tdata,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready,
  output logic [N:0]   count,
  output logic         almost_full,
  output logic         empty
);

  localparam int unsigned Depth  = 2**N;
  localparam logic [N:0]  DepthC = (N+1)'(Depth);
  localparam logic [N:0]  AfullC = (N+1)'(AFULL_THR);
  localparam logic [N:0]  One    = (N+1)'(1);

  logic [B-1:0] mem [Depth];
  logic [B-1:0] dob_q;

  logic [N:0]   wr_ptr_q, wr_ptr_d;
  logic [N:0]   rd_ptr_q, rd_ptr_d;
  logic [N:0]   count_q, count_d;
  logic         s1_valid_q, s1_valid_d;
  logic         s2_valid_q, s2_valid_d;
  logic [B-1:0] s2_data_q, s2_data_d;

  logic push, pop, enb, load;

  always_comb begin
    s_axis_tready = aresetn && !flush && (count_q < DepthC);
    push          = s_axis_tvalid && s_axis_tready;
    pop           = s2_valid_q && m_axis_tready;
    // Pointers are registered, so a word written this edge is only readable from the next one.
    enb           = (wr_ptr_q != rd_ptr_q) && !(s1_valid_q && s2_valid_q && !pop) && !flush;
    load          = s1_valid_q && (!s2_valid_q || pop);

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;

    if (push) wr_ptr_d = wr_ptr_q + One;
    if (enb)  rd_ptr_d = rd_ptr_q + One;

    unique case ({push, pop})
      2'b10:   count_d = count_q + One;
      2'b01:   count_d = count_q - One;
      default: count_d = count_q;
    endcase

    if (enb) begin
      s1_valid_d = 1'b1;
    end else if (load) begin
      s1_valid_d = 1'b0;
    end

    if (load) begin
      s2_valid_d = 1'b1;
      s2_data_d  = dob_q;
    end else if (pop) begin
      s2_valid_d = 1'b0;
    end

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
      s2_data_d  = '0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
    end
  end

  // RAM ports carry no reset so they map onto block RAM.
  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr_q[N-1:0]] <= s_axis_tdata;
  end

  always_ff @(posedge aclk) begin
    if (enb) dob_q <= mem[rd_ptr_q[N-1:0]];
  end

  assign m_axis_tdata  = s2_data_q;
  assign m_axis_tvalid = s2_valid_q;
  assign count         = count_q;
  assign almost_full   = (count_q >= AfullC);
  assign empty         = (count_q == '0);

endmodule

// File: tb/tb_bram_fifo_axis_fwft.sv
// Scoreboard bench for bram_fifo_axis_fwft: accepted words are queued by a recorder,
// a negedge monitor compares every output against the queue-based model.
module tb_bram_fifo_axis_fwft;
  localparam int unsigned N     = 4;
  localparam int unsigned B     = 16;
  localparam int unsigned Depth = 16;
  localparam int unsigned Afull = 12;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic         flush = 1'b0;
  logic [B-1:0] s_tdata = '0;
  logic         s_tvalid = 1'b0;
  logic         s_tready;
  logic [B-1:0] m_tdata;
  logic         m_tvalid;
  logic         m_tready = 1'b0;
  logic [N:0]   count;
  logic         almost_full;
  logic         empty;

  always #5 aclk = ~aclk;

  bram_fifo_axis_fwft #(
    .N         (N),
    .B         (B),
    .AFULL_THR (Afull)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .flush         (flush),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .count         (count),
    .almost_full   (almost_full),
    .empty         (empty)
  );

  int checks = 0;
  int errors = 0;
  logic [B-1:0] exp_q[$];
  int cyc = 0;
  int pops = 0;
  int first_pop = -1;
  int last_pop = -1;
  int max_cnt = 0;
  bit streaming = 0;
  bit prev_stall = 0;
  logic [B-1:0] prev_data = '0;

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: compares outputs against the model, then retires the word being popped.
  always @(negedge aclk) begin
    cyc++;
    if (!aresetn) begin
      check("rst_tvalid", int'(m_tvalid), 0);
      check("rst_count", int'(count), 0);
      check("rst_empty", int'(empty), 1);
      check("rst_tdata", int'(m_tdata), 0);
      check("rst_tready", int'(s_tready), 0);
      exp_q.delete();
      prev_stall = 0;
    end else begin
      check("count", int'(count), exp_q.size());
      check("empty", int'(empty), int'(exp_q.size() == 0));
      check("almost_full", int'(almost_full), int'(exp_q.size() >= Afull));
      check("s_tready", int'(s_tready), int'(!flush && exp_q.size() < Depth));
      if (prev_stall) begin
        check("stall_tvalid", int'(m_tvalid), 1);
        check("stall_tdata", int'(m_tdata), int'(prev_data));
      end
      if (streaming && int'(count) > max_cnt) max_cnt = int'(count);
      if (m_tvalid) begin
        check("tvalid_has_word", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          check("tdata", int'(m_tdata), int'(exp_q[0]));
          if (m_tready && !flush) begin
            void'(exp_q.pop_front());
            pops++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
          end
        end
      end
      if (flush) exp_q.delete();
      prev_stall = m_tvalid && !m_tready && !flush;
      prev_data  = m_tdata;
    end
  end

  // Recorder: every accepted input word becomes an expected output word.
  always begin
    @(negedge aclk);
    #1;
    if (aresetn && s_tvalid && s_tready) exp_q.push_back(s_tdata);
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic drain(string name);
    m_tready = 1'b1;
    s_tvalid = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge aclk);
      if (count == '0 && !m_tvalid) break;
      tick();
    end
    check(name, int'(empty), 1);
    tick();
  endtask

  // Push one word into an empty FIFO and expect it on the output two edges later.
  task automatic latency_probe(string name, logic [B-1:0] d);
    m_tready = 1'b1;
    s_tdata  = d;
    s_tvalid = 1'b1;
    tick();
    s_tvalid = 1'b0;
    @(negedge aclk);
    check({name, "_v_e0"}, int'(m_tvalid), 0);
    tick();
    @(negedge aclk);
    check({name, "_v_e1"}, int'(m_tvalid), 0);
    tick();
    @(negedge aclk);
    check({name, "_v_e2"}, int'(m_tvalid), 1);
    check({name, "_data"}, int'(m_tdata), int'(d));
    check({name, "_cnt1"}, int'(count), 1);
    tick();
    @(negedge aclk);
    check({name, "_cnt0"}, int'(count), 0);
    tick();
  endtask

  task automatic fill_ten();
    m_tready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s_tdata  = B'($urandom);
      s_tvalid = 1'b1;
      tick();
    end
    s_tvalid = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int words;
    // Reset held with inputs toggling.
    for (int i = 0; i < 4; i++) begin
      s_tvalid = 1'($urandom);
      s_tdata  = B'($urandom);
      m_tready = 1'($urandom);
      flush    = 1'($urandom);
      tick();
    end
    aresetn  = 1'b1;
    flush    = 1'b0;
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    @(negedge aclk);
    check("release_tready", int'(s_tready), 1);
    tick();

    latency_probe("lat", 16'h1234);

    // Fill to full with the consumer stalled, then drain.
    m_tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s_tdata  = B'(i);
      s_tvalid = 1'b1;
      @(negedge aclk);
      check("fill_count", int'(count), i);
      check("fill_afull", int'(almost_full), int'(i >= 12));
      tick();
    end
    s_tdata = 16'h0099;
    @(negedge aclk);
    check("full_count", int'(count), 16);
    check("full_tready", int'(s_tready), 0);
    check("full_afull", int'(almost_full), 1);
    tick();
    drain("fill_drain_empty");

    // Back-to-back streaming through pointer wrap.
    pops = 0;
    first_pop = -1;
    max_cnt = 0;
    streaming = 1;
    m_tready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      s_tdata  = B'(i);
      s_tvalid = 1'b1;
      tick();
    end
    drain("stream_drain_empty");
    streaming = 0;
    check("stream_pops", pops, 100);
    check("stream_span", last_pop - first_pop, 99);
    check("stream_max_count", int'(max_cnt <= 3), 1);

    // Random backpressure on both sides.
    words = 0;
    for (int c = 0; c < 20000 && words < 1000; c++) begin
      s_tvalid = 1'($urandom);
      s_tdata  = B'($urandom);
      m_tready = 1'($urandom);
      @(negedge aclk);
      if (s_tvalid && s_tready) words++;
      tick();
    end
    check("rand_words", words, 1000);
    drain("rand_drain_empty");

    // Flush mid-operation.
    fill_ten();
    m_tready = 1'b1;
    flush    = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge aclk);
    check("flush_count", int'(count), 0);
    check("flush_tvalid", int'(m_tvalid), 0);
    tick();
    latency_probe("flush_lat", 16'hBEEF);

    // Asynchronous reset mid-operation.
    fill_ten();
    m_tready = 1'b1;
    aresetn  = 1'b0;
    @(negedge aclk);
    check("areset_count", int'(count), 0);
    check("areset_tvalid", int'(m_tvalid), 0);
    tick();
    aresetn = 1'b1;
    tick();
    latency_probe("areset_lat", 16'hBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
